// File: rtl/frame_receiver_if.sv
// Consumer-side bundle of frame_receiver: received word, error flags and valid/ready handshake.
// break_o exists only when FRAME_RECEIVER_BREAK_DETECT_EN is defined.
interface frame_receiver_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] char_o;
    logic                 valid_o;
    logic                 ready_i;
    logic                 parity_err_o;
    logic                 frame_err_o;
    logic                 overrun_o;
`ifdef FRAME_RECEIVER_BREAK_DETECT_EN
    logic                 break_o;
`endif

    modport master (
`ifdef FRAME_RECEIVER_BREAK_DETECT_EN
        output break_o,
`endif
        output char_o, valid_o, parity_err_o, frame_err_o, overrun_o,
        input  ready_i
    );

    modport slave (
`ifdef FRAME_RECEIVER_BREAK_DETECT_EN
        input  break_o,
`endif
        input  char_o, valid_o, parity_err_o, frame_err_o, overrun_o,
        output ready_i
    );
endinterface

// File: rtl/frame_receiver.sv
// Oversampling asynchronous serial frame receiver with a one-deep valid/ready output register.
// Optional break detection is enabled by defining FRAME_RECEIVER_BREAK_DETECT_EN.
module frame_receiver #(
    parameter int OVERSAMPLING  = 16,
    parameter int DATA_BITS     = 8,
    parameter int PARITY        = 0,
    parameter int STOP_BITS     = 1,
    parameter int IDLE_POLARITY = 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              rx_i,
    frame_receiver_if.master  bus
);
    localparam int   CNT_W    = $clog2(OVERSAMPLING);
    localparam int   BIT_W    = $clog2(DATA_BITS);
    localparam logic IDLE_LVL = (IDLE_POLARITY != 0);
    localparam logic [CNT_W-1:0] HALF      = CNT_W'(OVERSAMPLING / 2);
    localparam logic [CNT_W-1:0] LAST      = CNT_W'(OVERSAMPLING - 1);
    localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t               state, state_nxt;
    logic                 rx_meta, rx_sync;
    logic [CNT_W-1:0]     cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic                 armed;
    logic                 brk_hold;
    logic                 sample;
    logic                 frame_done;
    logic                 frame_break;
    logic [DATA_BITS-1:0] shift;
    logic                 par_bit;
    logic                 ferr_acc;
    logic                 line_idle;
    logic                 ferr_fin;
    logic                 perr_fin;

    function automatic logic parity_error(input logic [DATA_BITS-1:0] d, input logic p);
        logic x;
        x = (^d) ^ p;
        case (PARITY)
            1:       return x;
            2:       return ~x;
            default: return 1'b0;
        endcase
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_meta <= IDLE_LVL;
            rx_sync <= IDLE_LVL;
        end else begin
            rx_meta <= rx_i;
            rx_sync <= rx_meta;
        end
    end

    assign line_idle = (rx_sync == IDLE_LVL);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= S_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        sample     = 1'b0;
        frame_done = 1'b0;
        case (state)
            S_IDLE: begin
                if (armed && !brk_hold && !line_idle) state_nxt = S_START;
            end
            S_START: begin
                sample = (cnt == HALF);
                if (sample) state_nxt = line_idle ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                sample = (cnt == LAST);
                if (sample && bit_cnt == LAST_DATA)
                    state_nxt = (PARITY == 0) ? S_STOP : S_PARITY;
            end
            S_PARITY: begin
                sample = (cnt == LAST);
                if (sample) state_nxt = S_STOP;
            end
            S_STOP: begin
                sample = (cnt == LAST);
                if (sample && bit_cnt == LAST_STOP) begin
                    state_nxt  = S_IDLE;
                    frame_done = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // A start edge is accepted only after the line has been seen idle in IDLE,
    // so a low line left over from reset or a broken frame is not taken as a start.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt     <= '0;
            bit_cnt <= '0;
            armed   <= 1'b0;
        end else begin
            if (state == S_IDLE) begin
                armed   <= armed | line_idle;
                bit_cnt <= '0;
                if (brk_hold && line_idle && cnt != LAST) cnt <= cnt + 1'b1;
                else                                      cnt <= '0;
            end else begin
                armed <= 1'b0;
                if (sample) cnt <= '0;
                else        cnt <= cnt + 1'b1;
                if (sample && (state == S_DATA || state == S_STOP)) begin
                    if (state == S_DATA && bit_cnt == LAST_DATA) bit_cnt <= '0;
                    else                                         bit_cnt <= bit_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (state == S_IDLE) ferr_acc <= 1'b0;
        if (sample) begin
            case (state)
                S_DATA:   shift    <= {rx_sync, shift[DATA_BITS-1:1]};
                S_PARITY: par_bit  <= rx_sync;
                S_STOP:   ferr_acc <= ferr_acc | ~line_idle;
                default:  ;
            endcase
        end
    end

    assign ferr_fin = ferr_acc | ~line_idle;
    assign perr_fin = parity_error(shift, par_bit);

`ifdef FRAME_RECEIVER_BREAK_DETECT_EN
    logic stop_all;

    always_ff @(posedge clk_i) begin
        if (state == S_IDLE)                  stop_all <= 1'b1;
        else if (sample && state == S_STOP)   stop_all <= stop_all & ~line_idle;
    end

    assign frame_break = (shift == {DATA_BITS{~IDLE_LVL}}) && stop_all && !line_idle;

    // After a break the receiver waits for a full bit period of idle line before re-arming.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            brk_hold    <= 1'b0;
            bus.break_o <= 1'b0;
        end else begin
            bus.break_o <= frame_done && frame_break;
            if (frame_done && frame_break)
                brk_hold <= 1'b1;
            else if (state == S_IDLE && brk_hold && line_idle && cnt == LAST)
                brk_hold <= 1'b0;
        end
    end
`else
    assign frame_break = 1'b0;
    assign brk_hold    = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bus.char_o       <= '0;
            bus.valid_o      <= 1'b0;
            bus.parity_err_o <= 1'b0;
            bus.frame_err_o  <= 1'b0;
            bus.overrun_o    <= 1'b0;
        end else begin
            bus.overrun_o <= 1'b0;
            if (frame_done && !frame_break) begin
                if (!bus.valid_o || bus.ready_i) begin
                    bus.char_o       <= shift;
                    bus.parity_err_o <= perr_fin;
                    bus.frame_err_o  <= ferr_fin;
                    bus.valid_o      <= 1'b1;
                end else begin
                    bus.overrun_o <= 1'b1;
                end
            end else if (bus.ready_i) begin
                bus.valid_o <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_frame_receiver.sv
// Directed bench for frame_receiver: OVERSAMPLING=16, 8 data bits, even parity, 1 stop, idle high.
module tb_frame_receiver;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic rx    = 1'b1;

    always #5 clk = ~clk;

    frame_receiver_if #(.DATA_BITS(8)) bus ();

    frame_receiver #(
        .OVERSAMPLING(16), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .IDLE_POLARITY(1)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .rx_i  (rx),
        .bus   (bus)
    );

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    int start_cyc  = 0;

    int         valid_cnt  = 0;
    int         ovr_cnt    = 0;
    int         brk_cnt    = 0;
    int         rise_cyc   = 0;
    logic [7:0] last_char  = 8'h00;
    logic       last_perr  = 1'b0;
    logic       last_ferr  = 1'b0;
    logic       prev_valid = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.valid_o === 1'b1) begin
            valid_cnt++;
            last_char = bus.char_o;
            last_perr = bus.parity_err_o;
            last_ferr = bus.frame_err_o;
            if (prev_valid !== 1'b1) rise_cyc = cyc;
        end
        if (bus.overrun_o === 1'b1) ovr_cnt++;
`ifdef FRAME_RECEIVER_BREAK_DETECT_EN
        if (bus.break_o === 1'b1) brk_cnt++;
`endif
        prev_valid = bus.valid_o;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] make_frame(input logic [7:0] d, input logic bad_par);
        return {5'b0, 1'b1, (^d) ^ bad_par, d, 1'b0};
    endfunction

    task automatic drive_bits(input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            rx = bits[i];
            repeat (16) @(negedge clk);
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic bad_par);
        @(negedge clk);
        start_cyc = cyc;
        drive_bits(make_frame(d, bad_par), 11);
        rx = 1'b1;
        repeat (32) @(negedge clk);
    endtask

    int v0, o0, b0, lat;
    logic [15:0] f;

    initial begin
        bus.ready_i = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_valid",  32'(bus.valid_o),      32'd0);
        chk("rst_char",   32'(bus.char_o),       32'd0);
        chk("rst_perr",   32'(bus.parity_err_o), 32'd0);
        chk("rst_ferr",   32'(bus.frame_err_o),  32'd0);
        chk("rst_ovr",    32'(bus.overrun_o),    32'd0);
`ifdef FRAME_RECEIVER_BREAK_DETECT_EN
        chk("rst_brk",    32'(bus.break_o),      32'd0);
`endif
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        // Good frame 0xA5
        v0 = valid_cnt; o0 = ovr_cnt;
        send_byte(8'hA5, 1'b0);
        lat = rise_cyc - start_cyc;
        chk("a5_vcycles", 32'(valid_cnt - v0), 32'd1);
        chk("a5_char",    32'(last_char),      32'hA5);
        chk("a5_perr",    32'(last_perr),      32'd0);
        chk("a5_ferr",    32'(last_ferr),      32'd0);
        chk("a5_latency", 32'(lat > 0 && lat <= 179), 32'd1);
        chk("a5_no_ovr",  32'(ovr_cnt - o0),   32'd0);

        // Wrong parity 0x3C
        v0 = valid_cnt;
        send_byte(8'h3C, 1'b1);
        chk("3c_vcycles", 32'(valid_cnt - v0), 32'd1);
        chk("3c_char",    32'(last_char),      32'h3C);
        chk("3c_perr",    32'(last_perr),      32'd1);
        chk("3c_ferr",    32'(last_ferr),      32'd0);

        // Overrun with consumer stalled
        @(negedge clk);
        bus.ready_i = 1'b0;
        o0 = ovr_cnt;
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        chk("ovr_valid_held", 32'(bus.valid_o),      32'd1);
        chk("ovr_char_held",  32'(bus.char_o),       32'h11);
        chk("ovr_perr_held",  32'(bus.parity_err_o), 32'd0);
        chk("ovr_pulses",     32'(ovr_cnt - o0),     32'd1);
        bus.ready_i = 1'b1;
        @(negedge clk);
        chk("ovr_valid_drop", 32'(bus.valid_o),      32'd0);

        // Short glitch, then 0x7E
        v0 = valid_cnt;
        rx = 1'b0;
        repeat (5) @(negedge clk);
        rx = 1'b1;
        repeat (48) @(negedge clk);
        chk("glitch_no_valid", 32'(valid_cnt - v0), 32'd0);
        v0 = valid_cnt;
        send_byte(8'h7E, 1'b0);
        chk("7e_vcycles", 32'(valid_cnt - v0), 32'd1);
        chk("7e_char",    32'(last_char),      32'h7E);
        chk("7e_perr",    32'(last_perr),      32'd0);
        chk("7e_ferr",    32'(last_ferr),      32'd0);

        // Reset during data bit 4, then 0x81
        v0 = valid_cnt;
        f = make_frame(8'h55, 1'b0);
        drive_bits(f, 5);
        rx = f[5];
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (3) @(negedge clk);
        chk("midrst_valid", 32'(bus.valid_o), 32'd0);
        chk("midrst_char",  32'(bus.char_o),  32'd0);
        rst_n = 1'b1;
        repeat (48) @(negedge clk);
        chk("midrst_no_valid", 32'(valid_cnt - v0), 32'd0);
        send_byte(8'h81, 1'b0);
        chk("81_vcycles", 32'(valid_cnt - v0), 32'd1);
        chk("81_char",    32'(last_char),      32'h81);
        chk("81_perr",    32'(last_perr),      32'd0);
        chk("81_ferr",    32'(last_ferr),      32'd0);

        // Line low for 12 bit times
        v0 = valid_cnt; b0 = brk_cnt;
        @(negedge clk);
        rx = 1'b0;
        repeat (12 * 16) @(negedge clk);
        rx = 1'b1;
        repeat (64) @(negedge clk);
`ifdef FRAME_RECEIVER_BREAK_DETECT_EN
        chk("brk_pulses",   32'(brk_cnt - b0),   32'd1);
        chk("brk_no_valid", 32'(valid_cnt - v0), 32'd0);
`else
        chk("brk_vcycles",  32'(valid_cnt - v0), 32'd1);
        chk("brk_char",     32'(last_char),      32'h00);
        chk("brk_ferr",     32'(last_ferr),      32'd1);
        chk("brk_perr",     32'(last_perr),      32'd0);
`endif
        v0 = valid_cnt;
        send_byte(8'hC3, 1'b0);
        chk("c3_vcycles", 32'(valid_cnt - v0), 32'd1);
        chk("c3_char",    32'(last_char),      32'hC3);
        chk("c3_ferr",    32'(last_ferr),      32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/frame_receiver.md
FRAME_RECEIVER -- requirements
Module: frame_receiver

Interface
REQ-001 Parameter OVERSAMPLING, default 16, clock cycles per bit period (range 4..255).
REQ-002 Parameter DATA_BITS, default 8, data bits per frame (range 5..9), LSB first.
REQ-003 Parameter PARITY, default 0, parity mode: 0 none, 1 even, 2 odd.
REQ-004 Parameter STOP_BITS, default 1, stop bits checked per frame (1 or 2).
REQ-005 Parameter IDLE_POLARITY, default 1, line level when idle; the start bit is its inverse.
REQ-006 clk_i  input  1  sole clock; all state on its rising edge.
REQ-007 rst_ni  input  1  asynchronous, active-low reset.
REQ-008 rx_i  input  1  asynchronous serial line.
REQ-009 char_o  output  DATA_BITS  received data word, bit 0 = first data bit received.
REQ-010 valid_o  output  1  char_o and error flags hold a frame.
REQ-011 ready_i  input  1  consumer accepts the frame when valid_o and ready_i are both high.
REQ-012 parity_err_o  output  1  held frame failed parity; always 0 when PARITY = 0.
REQ-013 frame_err_o  output  1  held frame had a stop sample at the non-idle level.
REQ-014 overrun_o  output  1  one-cycle pulse when a completed frame is discarded.

Function
REQ-015 rx_i shall pass through a 2-flop synchronizer reset to IDLE_POLARITY; all decoding uses the synchronized value.
REQ-016 FSM states: IDLE, START, DATA, PARITY, STOP; PARITY is skipped when PARITY = 0.
REQ-017 IDLE -> START on the first synchronized non-idle sample; the bit counter shall then load 0.
REQ-018 START samples at count OVERSAMPLING/2; an idle-level sample is a false start -> IDLE, no output.
REQ-019 Each later bit shall be sampled exactly OVERSAMPLING cycles after the previous sample.
REQ-020 DATA shall shift in DATA_BITS samples; then go to PARITY, or to STOP when PARITY = 0.
REQ-021 Parity error: even mode, XOR of data and parity sample = 1; odd mode, that XOR = 0.
REQ-022 STOP samples STOP_BITS times; any non-idle stop sample sets the frame error; after the last stop sample -> IDLE with no wait to the end of the bit.
REQ-023 A completed frame shall load char_o and the error flags and assert valid_o on the cycle after the last stop sample.
REQ-024 valid_o stays high, with char_o and the flags stable, until a cycle with ready_i = 1.
REQ-025 If a frame completes while valid_o = 1 and ready_i = 0, the new frame is discarded, the held frame is kept, and overrun_o pulses for one cycle.
REQ-026 If a frame completes on the same cycle that valid_o and ready_i are both high, the new frame is loaded, valid_o stays high, and there is no overrun.
REQ-027 A frame with errors is still presented through valid_o; the flags describe that frame only.
REQ-028 Counters shall be $clog2-sized; no counter wraps inside a frame.

Reset
REQ-029 While rst_ni = 0: FSM = IDLE; counters 0; synchronizer = IDLE_POLARITY; char_o = 0; valid_o, parity_err_o, frame_err_o, overrun_o = 0.
REQ-030 Reset in mid-frame aborts the frame without output; after release, the first start edge is found only after the line has been seen idle for one or more cycles.

Configuration
REQ-031 Macro FRAME_RECEIVER_BREAK_DETECT_EN: when defined, add output break_o, 1 bit.
REQ-032 With the macro, a frame whose data and stop samples are all non-idle produces no valid_o; break_o pulses for one cycle on the cycle after the last stop sample.
REQ-033 With the macro, the receiver then stays in IDLE until the line has been idle for OVERSAMPLING cycles.
REQ-034 Without the macro, break_o is absent; a break frame is delivered as char_o = 0 with frame_err_o = 1.

Verification (OVERSAMPLING=16, DATA_BITS=8, PARITY=1, STOP_BITS=1, IDLE_POLARITY=1 unless stated)
REQ-035 Send 0xA5 with correct even parity, ready_i=1 -> valid_o for 1 cycle, char_o=0xA5, flags 0, within 16*11+3 cycles of the start edge.
REQ-036 Send 0x3C with inverted parity bit -> char_o=0x3C, parity_err_o=1, frame_err_o=0.
REQ-037 Hold ready_i=0 and send 0x11 then 0x22 -> char_o stays 0x11, overrun_o pulses once; ready_i=1 -> valid_o drops the next cycle.
REQ-038 Apply a 5-cycle low glitch -> no valid_o; a 0x7E sent afterwards is received correctly.
REQ-039 Assert rst_ni=0 during data bit 4, then send 0x81 -> only 0x81 is delivered, with no flags set.
REQ-040 Hold the line low for 12 bit times -> with FRAME_RECEIVER_BREAK_DETECT_EN, break_o pulses once and there is no valid_o; without it, valid_o with char_o=0x00 and frame_err_o=1.
